tdm_demux4: RTL and testbench



---
 rtl/tdm_demux4.sv | 120 ++++++++++++
 tb/tb_tdm_demux4.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: locks to frame_sync, collects one sample per slot
// and presents all four channels together with a one-cycle frame strobe.
//
// state  | meaning
// HUNT   | waiting for a framed slot-0 sample; unframed samples are dropped
// LOCKED | collecting slots 00..11; a frame_sync off slot 00 restarts the frame
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s0,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             fv_q, fv_d, se_q, se_d;
  logic             resync;

  // A frame_sync anywhere but slot 00 while locked discards the partial frame.
  assign resync = (state_q == LOCKED) && din_valid && frame_sync && (slot_q != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'b00;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && din_valid && frame_sync) state_d = LOCKED;
  end

  always_comb begin
    slot_d = slot_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    fv_d   = 1'b0;
    se_d   = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          sh0_d  = din;
          slot_d = 2'b01;
        end
      end else if (resync) begin
        se_d   = 1'b1;
        sh0_d  = din;
        slot_d = 2'b01;
      end else begin
        case (slot_q)
          2'b00: begin sh0_d = din; slot_d = 2'b01; end
          2'b01: begin sh1_d = din; slot_d = 2'b10; end
          2'b10: begin sh2_d = din; slot_d = 2'b11; end
          default: begin
            a_d    = sh0_q;
            b_d    = sh1_q;
            c_d    = sh2_q;
            d_d    = din;
            fv_d   = 1'b1;
            slot_d = 2'b00;
          end
        endcase
      end
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign s1          = slot_q[1];
  assign s0          = slot_q[0];
  assign frame_valid = fv_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: expected frames are queued as stimulus is driven
// and checked against the DUT whenever frame_valid fires.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] a, b, c, d;
  logic       s1, s0, frame_valid, locked, sync_err;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s0(s0),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on frame_valid, else outputs must hold.
  always @(posedge clk) begin
    logic r;
    logic [31:0] got;
    r = rst_n;
    #1;
    if (!r) held = '0;
    else if (frame_valid) begin
      fv_cnt++;
      if (exp_q.size() == 0) chk("unexpected_frame_valid", 32'd1, 32'd0);
      else held = exp_q.pop_front();
    end
    if (sync_err) se_cnt++;
    got = {a, b, c, d};
    chk("abcd", got, held);
  end

  task automatic step(input logic [7:0] v, input logic fs, input logic vld);
    @(negedge clk);
    din = v;
    frame_sync = fs;
    din_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_abcd"}, {a, b, c, d}, 32'h0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_slot"}, {30'd0, s1, s0}, 32'd0);
    chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_se"}, {31'd0, sync_err}, 32'd0);
  endtask

  initial begin
    int fv0, se0;
    logic [7:0] w[4];

    // reset / idle
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    idle(5);
    chk_clear("reset");

    // basic frame
    step(8'h11, 1'b1, 1'b1);
    chk("basic_locked", {31'd0, locked}, 32'd1);
    chk("basic_slot1", {30'd0, s1, s0}, 32'd1);
    step(8'h22, 1'b0, 1'b1);
    chk("basic_slot2", {30'd0, s1, s0}, 32'd2);
    step(8'h33, 1'b0, 1'b1);
    chk("basic_slot3", {30'd0, s1, s0}, 32'd3);
    chk("basic_no_fv", {31'd0, frame_valid}, 32'd0);
    exp_q.push_back(32'h11223344);
    step(8'h44, 1'b0, 1'b1);
    chk("basic_fv", {31'd0, frame_valid}, 32'd1);
    chk("basic_slot0", {30'd0, s1, s0}, 32'd0);
    chk("basic_abcd", {a, b, c, d}, 32'h11223344);
    idle(1);
    chk("basic_fv_drop", {31'd0, frame_valid}, 32'd0);

    // HUNT discard and sparse input
    do_reset();
    idle(1);
    chk_clear("rst2");
    step(8'hAA, 1'b0, 1'b1);
    chk("hunt_locked_a", {31'd0, locked}, 32'd0);
    chk("hunt_slot_a", {30'd0, s1, s0}, 32'd0);
    step(8'hBB, 1'b0, 1'b1);
    chk("hunt_locked_b", {31'd0, locked}, 32'd0);
    step(8'h05, 1'b1, 1'b0);
    chk("ignored_sync", {31'd0, locked}, 32'd0);
    fv0 = fv_cnt;
    step(8'h01, 1'b1, 1'b1); idle(2);
    chk("gap_slot_hold", {30'd0, s1, s0}, 32'd1);
    step(8'h02, 1'b0, 1'b1); idle(2);
    step(8'h03, 1'b0, 1'b1); idle(2);
    exp_q.push_back(32'h01020304);
    step(8'h04, 1'b0, 1'b1);
    chk("gap_abcd", {a, b, c, d}, 32'h01020304);
    idle(2);
    chk("gap_fv_count", fv_cnt - fv0, 32'd1);

    // resync mid-frame
    fv0 = fv_cnt; se0 = se_cnt;
    step(8'h55, 1'b0, 1'b1);
    step(8'h66, 1'b0, 1'b1);
    step(8'h77, 1'b1, 1'b1);
    chk("resync_se", {31'd0, sync_err}, 32'd1);
    chk("resync_slot", {30'd0, s1, s0}, 32'd1);
    chk("resync_locked", {31'd0, locked}, 32'd1);
    step(8'h88, 1'b0, 1'b1);
    chk("resync_se_drop", {31'd0, sync_err}, 32'd0);
    step(8'h99, 1'b0, 1'b1);
    exp_q.push_back(32'h778899AA);
    step(8'hAA, 1'b0, 1'b1);
    chk("resync_abcd", {a, b, c, d}, 32'h778899AA);
    idle(1);
    chk("resync_se_count", se_cnt - se0, 32'd1);
    chk("resync_fv_count", fv_cnt - fv0, 32'd1);

    // continuous gapless stream
    fv0 = fv_cnt; se0 = se_cnt;
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 4; s++) w[s] = 8'($urandom_range(0, 255));
      exp_q.push_back({w[0], w[1], w[2], w[3]});
      for (int s = 0; s < 4; s++) begin
        step(w[s], s == 0, 1'b1);
        chk("cont_fv_cadence", {31'd0, frame_valid}, {31'd0, s == 3});
      end
      chk("cont_abcd", {a, b, c, d}, {w[0], w[1], w[2], w[3]});
    end
    idle(1);
    chk("cont_fv_count", fv_cnt - fv0, 32'd5);
    chk("cont_se_count", se_cnt - se0, 32'd0);

    // reset mid-frame, overriding a valid sample on the same edge
    step(8'h12, 1'b1, 1'b1);
    step(8'h34, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; din = 8'h56; din_valid = 1'b1; frame_sync = 1'b0;
    @(posedge clk); #1;
    chk_clear("midrst");
    @(negedge clk); rst_n = 1'b1; din_valid = 1'b0;
    idle(1);
    chk("midrst_hunt", {31'd0, locked}, 32'd0);
    step(8'hC1, 1'b1, 1'b1);
    step(8'hC2, 1'b0, 1'b1);
    step(8'hC3, 1'b0, 1'b1);
    exp_q.push_back(32'hC1C2C3C4);
    step(8'hC4, 1'b0, 1'b1);
    chk("midrst_abcd", {a, b, c, d}, 32'hC1C2C3C4);
    chk("midrst_fv", {31'd0, frame_valid}, 32'd1);
    idle(2);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
